sha_msg_sched: RTL and testbench



---
 rtl/sha_pkg.sv | 45 ++++
 rtl/sha_w_expand.sv | 41 ++++
 rtl/sha_msg_sched.sv | 125 ++++++++++++
 tb/tb_sha_msg_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA message-schedule blocks: modes, round counts,
// rotate helpers and the SHA-2 small-sigma functions.
package sha_pkg;

  localparam logic MODE_SHA1 = 1'b0;
  localparam logic MODE_SHA2 = 1'b1;

  localparam int ROUNDS_SHA1   = 80;
  localparam int ROUNDS_SHA256 = 64;
  localparam int ROUNDS_SHA512 = 80;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] sigma0_256(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1_256(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sigma0_512(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sigma1_512(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

endpackage

// File: rtl/sha_w_expand.sv
// Combinational next-word generator: given the 16-word window W_t..W_{t+15}
// it produces the word that enters at the top of the window, W_{t+16}.
module sha_w_expand
  import sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [16*WORD_W-1:0] win,
  input  logic                 mode,
  output logic [WORD_W-1:0]    nxt
);

  // Word k of win (bits [k*WORD_W +: WORD_W]) holds W_{t+k}.
  logic [WORD_W-1:0] w0, w1, w2, w8, w9, w13, w14;
  logic              unused_bits;

  assign w0  = win[0*WORD_W  +: WORD_W];
  assign w1  = win[1*WORD_W  +: WORD_W];
  assign w2  = win[2*WORD_W  +: WORD_W];
  assign w8  = win[8*WORD_W  +: WORD_W];
  assign w9  = win[9*WORD_W  +: WORD_W];
  assign w13 = win[13*WORD_W +: WORD_W];
  assign w14 = win[14*WORD_W +: WORD_W];

  assign unused_bits = ^{win[3*WORD_W +: 5*WORD_W], win[10*WORD_W +: 3*WORD_W],
                         win[15*WORD_W +: WORD_W], w2, w8, w13, mode};

  if (WORD_W == 64) begin : g_sha512
    assign nxt = sigma1_512(w14) + w9 + sigma0_512(w1) + w0;
  end else begin : g_sha32
    always_comb begin
      nxt = '0;
      if (mode == MODE_SHA2) begin
        nxt = sigma1_256(w14) + w9 + sigma0_256(w1) + w0;
      end else begin
        nxt = rotl32(w0 ^ w2 ^ w8 ^ w13, 1);
      end
    end
  end

endmodule

// File: rtl/sha_msg_sched.sv
// Message-schedule generator: loads one padded 16-word block and streams
// W_0..W_{R-1} to the round engine over a valid/ready handshake.
module sha_msg_sched
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] blk_data,
  input  logic                 blk_mode,
  input  logic                 flush,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_data,
  output logic [IDX_W-1:0]     w_idx,
  output logic                 w_last,
  output logic                 busy,
  output sched_state_e         dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where both valid and
  // ready are high. blk_ready and w_valid depend on state only, so neither
  // side sees a combinational path from the other's signal.

  sched_state_e        state_q, state_d;
  logic [WORD_W-1:0]   win_q [16];
  logic [16*WORD_W-1:0] win_flat;
  logic                mode_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    last_idx;
  logic [WORD_W-1:0]   next_word;
  logic                eff_mode;
  logic                accept;
  logic                hs;

  assign eff_mode = (WORD_W == 64) ? MODE_SHA2 : blk_mode;
  assign accept   = (state_q == ST_IDLE) && blk_valid && !flush;
  assign hs       = (state_q == ST_RUN) && w_ready && !flush;

  always_comb begin
    last_idx = IDX_W'(ROUNDS_SHA1 - 1);
    if (WORD_W == 64) begin
      last_idx = IDX_W'(ROUNDS_SHA512 - 1);
    end else if (mode_q == MODE_SHA2) begin
      last_idx = IDX_W'(ROUNDS_SHA256 - 1);
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_flat
    assign win_flat[k*WORD_W +: WORD_W] = win_q[k];
  end

  sha_w_expand #(
    .WORD_W (WORD_W)
  ) u_expand (
    .win  (win_flat),
    .mode (mode_q),
    .nxt  (next_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over both block acceptance and a word handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (blk_valid)        state_d = ST_RUN;
        ST_RUN:  if (w_ready && w_last) state_d = ST_IDLE;
        default:                        state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: blk_ready = 1'b1;
      ST_RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
      end
      default: blk_ready = 1'b0;
    endcase
  end

  // Block word 0 sits in the MSBs of blk_data and lands in window slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) win_q[k] <= '0;
      mode_q <= MODE_SHA1;
      idx_q  <= '0;
    end else if (flush) begin
      idx_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < 16; k++) win_q[k] <= blk_data[(15-k)*WORD_W +: WORD_W];
      mode_q <= eff_mode;
      idx_q  <= '0;
    end else if (hs) begin
      for (int k = 0; k < 15; k++) win_q[k] <= win_q[k+1];
      win_q[15] <= next_word;
      idx_q     <= idx_q + 1'b1;
    end
  end

  assign w_data    = win_q[0];
  assign w_idx     = idx_q;
  assign w_last    = (state_q == ST_RUN) && (idx_q == last_idx);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Self-checking bench for sha_msg_sched at WORD_W=32 and WORD_W=64.
module tb_sha_msg_sched;
  import sha_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         bv32, br32, bm32, fl32, wv32, wr32, wl32, busy32;
  logic [511:0] bd32;
  logic [31:0]  wd32;
  logic [6:0]   wi32;
  sched_state_e st32;

  logic          bv64, br64, bm64, fl64, wv64, wr64, wl64, busy64;
  logic [1023:0] bd64;
  logic [63:0]   wd64;
  logic [6:0]    wi64;
  sched_state_e  st64;

  sha_msg_sched #(.WORD_W(32), .IDX_W(7)) dut32 (
    .clk(clk), .rst_n(rst_n), .blk_valid(bv32), .blk_ready(br32), .blk_data(bd32),
    .blk_mode(bm32), .flush(fl32), .w_valid(wv32), .w_ready(wr32), .w_data(wd32),
    .w_idx(wi32), .w_last(wl32), .busy(busy32), .dbg_state(st32)
  );

  sha_msg_sched #(.WORD_W(64), .IDX_W(7)) dut64 (
    .clk(clk), .rst_n(rst_n), .blk_valid(bv64), .blk_ready(br64), .blk_data(bd64),
    .blk_mode(bm64), .flush(fl64), .w_valid(wv64), .w_ready(wr64), .w_data(wd64),
    .w_idx(wi64), .w_last(wl64), .busy(busy64), .dbg_state(st64)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [71:0] exp32_q[$];   // {last, idx, data64}
  logic [71:0] exp64_q[$];
  logic [63:0] gw[80];
  logic [63:0] blk_w[16];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit is64);
    logic [31:0] y;
    if (is64) return (x >> n) | (x << (64 - n));
    y = x[31:0];
    return {32'h0, (y >> n) | (y << (32 - n))};
  endfunction

  // Reference schedule in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form.
  task automatic build_model(input bit is64, input bit sha2);
    logic [63:0] mask, x, s0, s1;
    mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) gw[t] = blk_w[t] & mask;
    for (int t = 16; t < 80; t++) begin
      if (!sha2) begin
        x = gw[t-3] ^ gw[t-8] ^ gw[t-14] ^ gw[t-16];
        gw[t] = rr(x, 31, 1'b0);
      end else if (is64) begin
        s0 = rr(gw[t-15], 1, 1'b1) ^ rr(gw[t-15], 8, 1'b1) ^ (gw[t-15] >> 7);
        s1 = rr(gw[t-2], 19, 1'b1) ^ rr(gw[t-2], 61, 1'b1) ^ (gw[t-2] >> 6);
        gw[t] = s1 + gw[t-7] + s0 + gw[t-16];
      end else begin
        s0 = rr(gw[t-15], 7, 1'b0) ^ rr(gw[t-15], 18, 1'b0) ^ (gw[t-15] >> 3);
        s1 = rr(gw[t-2], 17, 1'b0) ^ rr(gw[t-2], 19, 1'b0) ^ (gw[t-2] >> 10);
        gw[t] = (s1 + gw[t-7] + s0 + gw[t-16]) & mask;
      end
    end
  endtask

  task automatic push32(input int n, input int rounds);
    for (int t = 0; t < n; t++) exp32_q.push_back({(t == rounds - 1), 7'(t), gw[t]});
  endtask

  task automatic set_abc(input bit is64);
    for (int k = 0; k < 16; k++) blk_w[k] = '0;
    blk_w[0]  = is64 ? 64'h6162638000000000 : 64'h61626380;
    blk_w[15] = is64 ? 64'h18 : 64'h18;
  endtask

  task automatic set_pattern();
    logic [31:0] v;
    for (int k = 0; k < 16; k++) begin
      v = 32'h9E3779B9 * 32'(k + 1);
      blk_w[k] = {32'h0, v ^ 32'h5A5A0F0F};
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon32
    logic [71:0] e, prev_val;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && wv32 && wr32 && !fl32) begin
        if (exp32_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL w32_unexpected: word idx %0d with empty expected queue", wi32);
        end else begin
          e = exp32_q.pop_front();
          check("w32_word", {wl32, wi32, 32'h0, wd32}, e);
        end
      end
      if (prev_stall && rst_n && wv32)
        check("w32_hold", {wl32, wi32, 32'h0, wd32}, prev_val);
      prev_stall = rst_n && wv32 && !wr32 && !fl32;
      prev_val   = {wl32, wi32, 32'h0, wd32};
    end
  end

  initial begin : mon64
    logic [71:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && wv64 && wr64 && !fl64) begin
        if (exp64_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL w64_unexpected: word idx %0d with empty expected queue", wi64);
        end else begin
          e = exp64_q.pop_front();
          check("w64_word", {wl64, wi64, wd64}, e);
        end
      end
    end
  end

  // ---------------- drivers (called at a negedge) ----------------
  task automatic offer32(input bit mode);
    int c;
    for (int k = 0; k < 16; k++) bd32[(15-k)*32 +: 32] = blk_w[k][31:0];
    bm32 = mode;
    bv32 = 1'b1;
    c = 0;
    while (!br32 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!br32) check("offer32_timeout", 72'(br32), 72'(1));
    @(negedge clk);
    bv32 = 1'b0;
    bd32 = {16{32'hDEADBEEF}};
    check("w32_first_valid", 72'(wv32), 72'(1));
    check("w32_first_idx", 72'(wi32), 72'(0));
  endtask

  // action 0: stream until word `upto` is consumed; 1: flush at `upto`;
  // 2: stall at `upto` and return in that cycle.
  task automatic run32(input int upto, input bit rnd, input int action);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      wr32 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fl32 = 1'b0;
      if (wv32 && wi32 == 7'(upto)) begin
        case (action)
          0: if (wr32) done = 1'b1;
          1: begin fl32 = 1'b1; wr32 = 1'b1; done = 1'b1; end
          default: begin wr32 = 1'b0; done = 1'b1; end
        endcase
      end
      if (action != 2 || !done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) check("run32_timeout", 72'(done), 72'(1));
    if (action != 2) begin
      fl32 = 1'b0;
      check("w32_idle_valid", 72'(wv32), 72'(0));
      check("w32_idle_blk_ready", 72'(br32), 72'(1));
      check("w32_idle_busy", 72'(busy32), 72'(0));
      check("w32_q_empty", 72'(exp32_q.size()), 72'(0));
    end
    if (action == 1) check("w32_flush_idx", 72'(wi32), 72'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bv32 = 0; bm32 = 0; fl32 = 0; wr32 = 0; bd32 = '0;
    bv64 = 0; bm64 = 0; fl64 = 0; wr64 = 0; bd64 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst32_blk_ready", 72'(br32), 72'(1));
    check("rst32_valid", 72'(wv32), 72'(0));
    check("rst32_busy", 72'(busy32), 72'(0));
    check("rst32_last", 72'(wl32), 72'(0));
    check("rst32_idx", 72'(wi32), 72'(0));
    check("rst64_blk_ready", 72'(br64), 72'(1));
    check("rst64_valid", 72'(wv64), 72'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // SHA-1 "abc": 80 words, W16 hand-computed
    set_abc(1'b0);
    build_model(1'b0, 1'b0);
    gw[0]  = 64'h61626380;
    gw[16] = 64'hC2C4C700;
    push32(80, 80);
    offer32(MODE_SHA1);
    run32(79, 1'b0, 0);

    // SHA-256 "abc": 64 words, W16/W17 hand-computed
    set_abc(1'b0);
    build_model(1'b0, 1'b1);
    gw[16] = 64'h61626380;
    gw[17] = 64'h000F0000;
    push32(64, 64);
    offer32(MODE_SHA2);
    run32(63, 1'b0, 0);

    // SHA-256 "abc" again with random back-pressure
    push32(64, 64);
    offer32(MODE_SHA2);
    run32(63, 1'b1, 0);

    // SHA-1 on a dense pattern block
    set_pattern();
    build_model(1'b0, 1'b0);
    push32(80, 80);
    offer32(MODE_SHA1);
    run32(79, 1'b0, 0);

    // SHA-256 on the pattern block with random back-pressure
    build_model(1'b0, 1'b1);
    push32(64, 64);
    offer32(MODE_SHA2);
    run32(63, 1'b1, 0);

    // flush at word 20, then a fresh SHA-256 block the next cycle
    build_model(1'b0, 1'b0);
    push32(20, 80);
    offer32(MODE_SHA1);
    run32(20, 1'b0, 1);
    set_abc(1'b0);
    build_model(1'b0, 1'b1);
    push32(64, 64);
    offer32(MODE_SHA2);
    run32(63, 1'b0, 0);

    // flush wins over block acceptance in the same cycle
    bv32 = 1'b1;
    fl32 = 1'b1;
    @(negedge clk);
    bv32 = 1'b0;
    fl32 = 1'b0;
    check("flush_blocks_accept_valid", 72'(wv32), 72'(0));
    check("flush_blocks_accept_busy", 72'(busy32), 72'(0));

    // asynchronous reset at word 40, then a full block recovers
    set_abc(1'b0);
    build_model(1'b0, 1'b0);
    push32(40, 80);
    offer32(MODE_SHA1);
    run32(40, 1'b0, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 72'(wv32), 72'(0));
    check("arst_last", 72'(wl32), 72'(0));
    check("arst_busy", 72'(busy32), 72'(0));
    check("arst_blk_ready", 72'(br32), 72'(1));
    check("arst_idx", 72'(wi32), 72'(0));
    check("arst_state", 72'(st32), 72'(ST_IDLE));
    check("arst_q_empty", 72'(exp32_q.size()), 72'(0));
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    build_model(1'b0, 1'b1);
    push32(64, 64);
    offer32(MODE_SHA2);
    run32(63, 1'b0, 0);

    // WORD_W=64 "abc" with blk_mode=0: forced to SHA-512, 80 words
    begin : t64
      int c;
      set_abc(1'b1);
      build_model(1'b1, 1'b1);
      gw[16] = 64'h6162638000000000;
      gw[17] = 64'h00030000000000C0;
      for (int t = 0; t < 80; t++) exp64_q.push_back({(t == 79), 7'(t), gw[t]});
      for (int k = 0; k < 16; k++) bd64[(15-k)*64 +: 64] = blk_w[k];
      bm64 = 1'b0;
      bv64 = 1'b1;
      @(negedge clk);
      bv64 = 1'b0;
      check("w64_first_valid", 72'(wv64), 72'(1));
      wr64 = 1'b1;
      c = 0;
      while (!(wv64 && wi64 == 7'd79) && c < 200) begin
        @(negedge clk);
        c++;
      end
      check("w64_reached_last", 72'(wl64), 72'(1));
      @(negedge clk);
      wr64 = 1'b0;
      check("w64_idle_valid", 72'(wv64), 72'(0));
      check("w64_idle_blk_ready", 72'(br64), 72'(1));
      check("w64_q_empty", 72'(exp64_q.size()), 72'(0));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
